// File: rtl/rf_bypass.sv
// Register file with write-through bypass and per-register pending (scoreboard) bits.
// Reads and busy flags are combinational; err pulses on unexpected writes or double issues.
module rf_bypass #(
  parameter int N = 16,
  parameter int R = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [R-1:0] i_read1Reg,
  input  logic [R-1:0] i_read2Reg,
  input  logic [R-1:0] i_writeReg,
  input  logic [N-1:0] i_writeData,
  input  logic         i_writeEn,
  input  logic         i_issueEn,
  input  logic [R-1:0] i_issueReg,
  output logic [N-1:0] o_read1Data,
  output logic [N-1:0] o_read2Data,
  output logic         o_busy1,
  output logic         o_busy2,
  output logic         o_err
);

  localparam int NREG = 1 << R;

  logic [N-1:0]    r_regs [NREG];
  logic [NREG-1:0] r_pending;
  logic            r_err;

  logic            w_hit1;
  logic            w_hit2;
  logic            w_retireIssue;
  logic            w_unexpWrite;
  logic            w_dblIssue;
  logic [NREG-1:0] w_pendNext;

  assign w_hit1        = i_writeEn && (i_writeReg == i_read1Reg);
  assign w_hit2        = i_writeEn && (i_writeReg == i_read2Reg);
  assign w_retireIssue = i_writeEn && (i_writeReg == i_issueReg);

  assign o_read1Data = w_hit1 ? i_writeData : r_regs[i_read1Reg];
  assign o_read2Data = w_hit2 ? i_writeData : r_regs[i_read2Reg];
  assign o_busy1     = r_pending[i_read1Reg] && !w_hit1;
  assign o_busy2     = r_pending[i_read2Reg] && !w_hit2;
  assign o_err       = r_err;

  assign w_unexpWrite = i_writeEn && !r_pending[i_writeReg];
  assign w_dblIssue   = i_issueEn && r_pending[i_issueReg] && !w_retireIssue;

  // Issue is applied after retire so a same-register producer keeps the bit set.
  always_comb begin
    w_pendNext = r_pending;
    if (i_writeEn) w_pendNext[i_writeReg] = 1'b0;
    if (i_issueEn) w_pendNext[i_issueReg] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_pending <= '0;
      r_err     <= 1'b0;
    end else begin
      if (i_writeEn) r_regs[i_writeReg] <= i_writeData;
      r_pending <= w_pendNext;
      r_err     <= w_unexpWrite || w_dblIssue;
    end
  end

endmodule

// File: tb/tb_rf_bypass.sv
// Directed-vector bench for rf_bypass: bypass, scoreboard busy flags, err pulses and async reset.
module tb_rf_bypass;

  localparam int N = 16;
  localparam int R = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [R-1:0] read1Reg, read2Reg, writeReg, issueReg;
  logic [N-1:0] writeData;
  logic         writeEn, issueEn;
  logic [N-1:0] read1Data, read2Data;
  logic         busy1, busy2, err;

  int vectors = 0;
  int miscompares = 0;

  rf_bypass #(.N(N), .R(R)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_read1Reg  (read1Reg),
    .i_read2Reg  (read2Reg),
    .i_writeReg  (writeReg),
    .i_writeData (writeData),
    .i_writeEn   (writeEn),
    .i_issueEn   (issueEn),
    .i_issueReg  (issueReg),
    .o_read1Data (read1Data),
    .o_read2Data (read2Data),
    .o_busy1     (busy1),
    .o_busy2     (busy2),
    .o_err       (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic [R-1:0] wr, input logic [N-1:0] wd,
                               input logic ie, input logic [R-1:0] ir);
    writeEn   = we;
    writeReg  = wr;
    writeData = wd;
    issueEn   = ie;
    issueReg  = ir;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    read1Reg = 3'd2;
    read2Reg = 3'd2;
    applyStimulus(1'b1, 3'd2, 16'h55AA, 1'b1, 3'd2);
    #1;
    checkOutput("rst_bypass_rd1", read1Data, 16'h55AA);
    checkOutput("rst_busy1", busy1, 1'b0);
    step();
    idle();
    #1;
    checkOutput("rst_write_ignored", read1Data, 16'h0000);
    checkOutput("rst_issue_ignored", busy2, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    rst_n = 1'b1;

    // All registers cleared, both ports.
    for (int i = 0; i < 8; i++) begin
      read1Reg = 3'(i);
      read2Reg = 3'(7 - i);
      #1;
      checkOutput($sformatf("reset_rd1_r%0d", i), read1Data, 16'h0000);
      checkOutput($sformatf("reset_rd2_r%0d", 7 - i), read2Data, 16'h0000);
    end
    checkOutput("reset_busy1", busy1, 1'b0);
    checkOutput("reset_busy2", busy2, 1'b0);
    checkOutput("reset_err", err, 1'b0);

    // Issue R3, stall, retire with bypass.
    step();
    applyStimulus(1'b0, '0, '0, 1'b1, 3'd3);
    step();
    idle();
    read1Reg = 3'd3;
    #1;
    checkOutput("r3_busy1_pending", busy1, 1'b1);
    checkOutput("r3_issue_no_err", err, 1'b0);
    applyStimulus(1'b1, 3'd3, 16'hBEEF, 1'b0, '0);
    #1;
    checkOutput("r3_bypass_data", read1Data, 16'hBEEF);
    checkOutput("r3_bypass_busy", busy1, 1'b0);
    step();
    idle();
    #1;
    checkOutput("r3_stored", read1Data, 16'hBEEF);
    checkOutput("r3_busy_after", busy1, 1'b0);
    checkOutput("r3_err_after", err, 1'b0);

    // R5 = 0x1234 via a proper issue/retire, then dual-port bypass of an unexpected write.
    applyStimulus(1'b0, '0, '0, 1'b1, 3'd5);
    step();
    applyStimulus(1'b1, 3'd5, 16'h1234, 1'b0, '0);
    step();
    idle();
    read1Reg = 3'd5;
    read2Reg = 3'd5;
    #1;
    checkOutput("r5_init", read1Data, 16'h1234);
    checkOutput("r5_init_err", err, 1'b0);
    applyStimulus(1'b1, 3'd5, 16'hA5A5, 1'b0, '0);
    #1;
    checkOutput("r5_bypass_rd1", read1Data, 16'hA5A5);
    checkOutput("r5_bypass_rd2", read2Data, 16'hA5A5);
    step();
    idle();
    #1;
    checkOutput("r5_unexp_err", err, 1'b1);
    checkOutput("r5_stored_rd2", read2Data, 16'hA5A5);
    step();
    checkOutput("r5_err_clears", err, 1'b0);

    // Retire and re-issue R2 in the same cycle: new producer wins.
    applyStimulus(1'b0, '0, '0, 1'b1, 3'd2);
    step();
    applyStimulus(1'b1, 3'd2, 16'h0001, 1'b1, 3'd2);
    step();
    idle();
    read1Reg = 3'd2;
    read2Reg = 3'd2;
    #1;
    checkOutput("r2_data", read1Data, 16'h0001);
    checkOutput("r2_busy1", busy1, 1'b1);
    checkOutput("r2_busy2", busy2, 1'b1);
    checkOutput("r2_err", err, 1'b0);

    // Independent issue R0 and retire R2 in one cycle.
    applyStimulus(1'b1, 3'd2, 16'h0002, 1'b1, 3'd0);
    step();
    idle();
    read1Reg = 3'd0;
    read2Reg = 3'd2;
    #1;
    checkOutput("indep_r0_busy", busy1, 1'b1);
    checkOutput("indep_r2_busy", busy2, 1'b0);
    checkOutput("indep_r2_data", read2Data, 16'h0002);
    checkOutput("indep_err", err, 1'b0);

    // Unexpected write to R6.
    applyStimulus(1'b1, 3'd6, 16'h00FF, 1'b0, '0);
    step();
    idle();
    read1Reg = 3'd6;
    #1;
    checkOutput("r6_data", read1Data, 16'h00FF);
    checkOutput("r6_err", err, 1'b1);
    step();
    checkOutput("r6_err_clears", err, 1'b0);

    // Double issue of R4 pulses err only on the second.
    applyStimulus(1'b0, '0, '0, 1'b1, 3'd4);
    step();
    checkOutput("r4_first_issue_err", err, 1'b0);
    step();
    idle();
    #1;
    checkOutput("r4_second_issue_err", err, 1'b1);
    step();
    checkOutput("r4_err_clears", err, 1'b0);

    // Both violations in one cycle give a single pulse.
    applyStimulus(1'b1, 3'd6, 16'h0F0F, 1'b1, 3'd4);
    step();
    idle();
    #1;
    checkOutput("both_err", err, 1'b1);
    step();
    checkOutput("both_err_clears", err, 1'b0);

    // Mid-cycle reset discards data and pending state.
    applyStimulus(1'b0, '0, '0, 1'b1, 3'd1);
    step();
    applyStimulus(1'b0, '0, '0, 1'b1, 3'd7);
    step();
    applyStimulus(1'b1, 3'd1, 16'h7FFF, 1'b0, '0);
    step();
    idle();
    read1Reg = 3'd1;
    read2Reg = 3'd7;
    #1;
    checkOutput("pre_rst_r1", read1Data, 16'h7FFF);
    checkOutput("pre_rst_r7_busy", busy2, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_r1", read1Data, 16'h0000);
    checkOutput("midrst_r7", read2Data, 16'h0000);
    checkOutput("midrst_busy1", busy1, 1'b0);
    checkOutput("midrst_busy2", busy2, 1'b0);
    checkOutput("midrst_err", err, 1'b0);
    read1Reg = 3'd4;
    #1;
    checkOutput("midrst_r4_busy", busy1, 1'b0);
    rst_n = 1'b1;
    step();
    checkOutput("postrst_r4_busy", busy1, 1'b0);
    checkOutput("postrst_r7_busy", busy2, 1'b0);
    checkOutput("postrst_err", err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rf_bypass.md
RF_BYPASS -- requirements
Module: rf_bypass

Interface
REQ-001 Parameter N, default 16: register data width in bits.
REQ-002 Parameter R, default 3: register address width; register count is 2^R (8).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 read1Reg  input  R  address of source operand 1, which feeds ALU InA.
REQ-006 read2Reg  input  R  address of source operand 2, which feeds ALU InB.
REQ-007 writeReg  input  R  writeback destination address.
REQ-008 writeData  input  N  writeback data, normally ALU Out or memory data.
REQ-009 writeEn  input  1  writeback strobe.
REQ-010 issueEn  input  1  an instruction is issued that will later write issueReg.
REQ-011 issueReg  input  R  destination of the issued instruction.
REQ-012 read1Data  output  N  operand 1 value.
REQ-013 read2Data  output  N  operand 2 value.
REQ-014 busy1  output  1  operand 1 awaits a pending write; the consumer must stall.
REQ-015 busy2  output  1  operand 2 awaits a pending write; the consumer must stall.
REQ-016 err  output  1  registered one-cycle pulse flagging a protocol violation.

Function
REQ-017 Storage: 2^R registers of N bits, plus one pending bit per register.
REQ-018 Write: on a clk edge with writeEn=1, regs[writeReg] <= writeData; all addresses, including 0, are ordinary writable registers.
REQ-019 Reads: read1Data and read2Data are combinational with zero latency.
REQ-020 Write-through bypass: when writeEn=1 and writeReg equals a read address, that port outputs writeData in the same cycle, not the stored value.
REQ-021 Both read ports may address the same register; each port bypasses independently.
REQ-022 Issue: on a clk edge with issueEn=1, pending[issueReg] <= 1.
REQ-023 Retire: on a clk edge with writeEn=1, pending[writeReg] <= 0, unless issueEn=1 with issueReg=writeReg in the same cycle, in which case pending stays 1 (new producer wins).
REQ-024 busyK = pending[readKReg] AND NOT (writeEn AND writeReg=readKReg); the bypass clears busy in the retire cycle.
REQ-025 Busy outputs are combinational, with no added cycle of delay.
REQ-026 Issue and write to different registers in the same cycle are independent and both take effect.
REQ-027 err <= 1 for exactly one cycle after any edge where writeEn=1 and pending[writeReg]=0 (unexpected write); the data is still written.
REQ-028 err <= 1 for exactly one cycle after any edge where issueEn=1, pending[issueReg]=1, and the same register is not retiring that cycle (double issue, WAW); pending stays 1.
REQ-029 If both error conditions occur in one cycle, err pulses once.
REQ-030 Without a new violation, err returns to 0 on the next edge.
REQ-031 Arithmetic: none; data passes through unmodified at width N.

Reset
REQ-032 rst_n=0 asynchronously clears all registers to 0, all pending bits to 0, and err to 0.
REQ-033 During reset: read outputs reflect the cleared storage (0), except that bypass still applies combinationally; busy1=busy2=0.
REQ-034 A reset asserted mid-operation discards all pending state; the first edge after deassertion behaves as though from power-up.
REQ-035 Writes and issues presented while rst_n=0 have no effect.

Verification
REQ-036 Reset, then read all 8 addresses on both ports -> 0x0000 everywhere; busy1=busy2=err=0.
REQ-037 Issue R3; next cycle read1Reg=3 -> busy1=1; then writeEn with R3=0xBEEF -> same cycle read1Data=0xBEEF, busy1=0; next cycle stored 0xBEEF, busy1=0, err=0.
REQ-038 R5 holds 0x1234; writeEn R5=0xA5A5 while read1Reg=read2Reg=5 -> both ports 0xA5A5 in the same cycle.
REQ-039 R2 pending; in one cycle writeEn R2=0x0001 and issueEn R2 -> next cycle R2=0x0001, pending[2]=1, busy on read of R2=1, err=0.
REQ-040 writeEn R6=0x00FF with R6 not pending -> R6=0x00FF and err=1 for one cycle; issue R4 twice in consecutive cycles -> err pulses on the second only.
REQ-041 Issue R1 and R7, write R1=0x7FFF, then pulse rst_n low mid-cycle -> immediately R1=0, R7=0, busy=0, err=0.
